// File: rtl/snac_pkg.sv
// Shared types and sizing helpers for the serial nibble adder controller.
package snac_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Nibble counter width; never below one bit so NIBBLES=1 still has a counter.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serial_nibble_adder_ctrl_nibble_add.sv
// Shared 4-bit add-with-carry slice, driven once per clock by the sequencer.
module nibble_add
  import snac_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);
  logic [NIBBLE_W:0] sum;

  assign sum     = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};
  assign {co, s} = sum;
endmodule

// File: rtl/serial_nibble_adder_ctrl.sv
// Wide add/subtract sequenced through one nibble adder, LSB nibble first,
// with valid/ready handshakes on operands and result.
module serial_nibble_adder_ctrl
  import snac_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_cin,
  input  logic         op_sub,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_carry,
  output logic         res_ovf,
  output logic         busy
);
  localparam int CW = cnt_w(NIBBLES);

  state_e                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic                               carry_q, carry_d;
  logic                               mode_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_q, b_q, sum_q;
  logic                               rcarry_q, ovf_q;
  logic                               accept, last;
  logic [NIBBLE_W-1:0]                nb_s;
  logic                               nb_co;

  assign last = (cnt_q == CW'(NIBBLES - 1));

  nibble_add u_add (
    .a  (a_q[cnt_q]),
    .b  (b_q[cnt_q]),
    .ci (carry_q),
    .s  (nb_s),
    .co (nb_co)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          accept  = 1'b1;
          state_d = RUN;
          cnt_d   = '0;
          // Subtract runs as A + ~B + !bin, so the seed carry flips in sub mode.
          carry_d = op_cin ^ op_sub;
        end
      end
      RUN: begin
        busy    = 1'b1;
        carry_d = nb_co;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      sum_q    <= '0;
      rcarry_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= op_a;
        b_q    <= op_sub ? ~op_b : op_b;
        mode_q <= op_sub;
      end
      if (state_q == RUN) begin
        sum_q[cnt_q] <= nb_s;
        if (last) begin
          rcarry_q <= nb_co ^ mode_q;
          ovf_q    <= (a_q[NIBBLES-1][NIBBLE_W-1] == b_q[NIBBLES-1][NIBBLE_W-1]) &&
                      (nb_s[NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);
        end
      end
    end
  end

  assign res_sum   = sum_q;
  assign res_carry = rcarry_q;
  assign res_ovf   = ovf_q;
endmodule

// File: tb/tb_serial_nibble_adder_ctrl.sv
// Scoreboard bench for serial_nibble_adder_ctrl with NIBBLES=4.
module tb_serial_nibble_adder_ctrl;
  localparam int N = 4;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_cin = 1'b0;
  logic         op_sub = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_sum;
  logic         res_carry;
  logic         res_ovf;
  logic         busy;

  serial_nibble_adder_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_carry(res_carry), .res_ovf(res_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = -1;
  int   prev_acc = -1;
  exp_t sb[$];
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [W:0]  full;
    if (!sub) begin
      full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.sum = full[W-1:0];
      e.c   = full[W];
      e.v   = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    end else begin
      e.sum = a - b - {{(W-1){1'b0}}, cin};
      e.c   = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, cin}));
      e.v   = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
    end
    return e;
  endfunction

  // Monitor: latency on each rising res_valid, scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid && !prev_v && acc_cyc >= 0)
        check("latency", cyc - acc_cyc, N);
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(res_sum), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_sum", 32'(res_sum), 32'(e.sum));
          check("res_carry", 32'(res_carry), 32'(e.c));
          check("res_ovf", 32'(res_ovf), 32'(e.v));
        end
      end
      prev_v <= res_valid;
    end else begin
      prev_v <= 1'b0;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input exp_t e);
    logic rdy;
    int   n;
    op_a = a; op_b = b; op_cin = cin; op_sub = sub;
    start_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = start_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 50);
    #1;
    if (!rdy) begin
      check("accept_timeout", 32'(rdy), 32'd1);
    end else begin
      sb.push_back(e);
      prev_acc = acc_cyc;
      acc_cyc  = cyc;
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_sum"}, 32'(res_sum), 32'd0);
    check({tag, "_res_carry"}, 32'(res_carry), 32'd0);
    check({tag, "_res_ovf"}, 32'(res_ovf), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    logic         rc, rs;

    #12;
    check_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, hand-computed
    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, exp_t'{16'h2233, 1'b0, 1'b0}); start_valid = 1'b0; wait_empty();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, exp_t'{16'h0000, 1'b1, 1'b0}); start_valid = 1'b0; wait_empty();
    issue(16'h7FFF, 16'h0000, 1'b1, 1'b0, exp_t'{16'h8000, 1'b0, 1'b1}); start_valid = 1'b0; wait_empty();
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, exp_t'{16'hFFFE, 1'b1, 1'b0}); start_valid = 1'b0; wait_empty();
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, exp_t'{16'h7FFF, 1'b0, 1'b1}); start_valid = 1'b0; wait_empty();

    // Backpressure: hold result while poking start_valid with other operands
    res_ready = 1'b0;
    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, exp_t'{16'h2233, 1'b0, 1'b0});
    start_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 20);
    check("bp_res_valid", 32'(res_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start_valid = (k % 2 == 0);
      op_a = 16'hAAAA; op_b = 16'h5555; op_cin = 1'b1; op_sub = 1'b1;
      @(negedge clk);
      check("bp_start_ready", 32'(start_ready), 32'd0);
      check("bp_valid_held", 32'(res_valid), 32'd1);
      check("bp_sum_held", 32'(res_sum), 32'h2233);
      check("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    start_valid = 1'b0;
    res_ready   = 1'b1;
    wait_empty();
    check("bp_idle_ready", 32'(start_ready), 32'd1);
    issue(16'h00F0, 16'h0010, 1'b0, 1'b0, exp_t'{16'h0100, 1'b0, 1'b0}); start_valid = 1'b0; wait_empty();

    // Asynchronous reset two cycles into RUN
    issue(16'h4321, 16'h1111, 1'b0, 1'b0, exp_t'{16'h5432, 1'b0, 1'b0});
    start_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    acc_cyc = -1;
    #1;
    check_reset_vals("midrun_reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(16'h0100, 16'h0001, 1'b1, 1'b1, exp_t'{16'h00FE, 1'b0, 1'b0}); start_valid = 1'b0; wait_empty();

    // Back-to-back random ops against the W-bit model
    res_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      issue(ra, rb, rc, rs, model(ra, rb, rc, rs));
      if (i > 0) check("throughput", acc_cyc - prev_acc, N + 2);
    end
    start_valid = 1'b0;
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
